// File: rtl/demux_dispatcher_if.sv
// Handshake and demux-facing signal bundle for demux_dispatcher.
// The master side is the upstream source plus the four channel sinks; the slave side is the dispatcher.
interface demux_dispatcher_if #(
  parameter int DW = 2
);
  logic [DW-1:0] in_data;
  logic [1:0]    in_dest;
  logic          mode;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [1:0]    sel;
  logic [3:0]    ch_valid;
  logic [3:0]    ch_ready;
  logic          drop;
  logic [7:0]    sent_cnt;

  modport master (
    output in_data, in_dest, mode, in_valid, ch_ready,
    input  in_ready, a, sel, ch_valid, drop, sent_cnt
  );

  modport slave (
    input  in_data, in_dest, mode, in_valid, ch_ready,
    output in_ready, a, sel, ch_valid, drop, sent_cnt
  );
endinterface

// File: rtl/demux_dispatcher.sv
// Sequences a 1-to-4 demux: accepts one word, offers it on a one-hot channel valid,
// retires it on that channel's ready, and retargets or drops it when the channel times out.
module demux_dispatcher #(
  parameter int DW      = 2,
  parameter int TIMEOUT = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  demux_dispatcher_if.slave   bus
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_a;
  logic [1:0]    r_sel;
  logic [1:0]    r_rr;
  logic [TW-1:0] r_timer;
  logic [1:0]    r_tries;
  logic          r_mode;
  logic          r_drop;
  logic [7:0]    r_sent;

  logic w_in_ready;
  logic w_accept;
  logic w_sel_ready;
  logic w_timeout;
  logic w_retry;

  // Ready is gated by reset so it falls immediately, not at the next edge.
  assign w_in_ready  = (r_state == S_IDLE) & ~i_rst;
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_sel_ready = bus.ch_ready[r_sel];
  assign w_timeout   = (r_timer == TLAST);
  // Only round-robin retargets, and only until every channel has been offered once.
  assign w_retry     = ~r_mode & (r_tries != 2'd3);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_sel   <= 2'd0;
      r_rr    <= 2'd0;
      r_timer <= '0;
      r_tries <= 2'd0;
      r_mode  <= 1'b0;
      r_drop  <= 1'b0;
      r_sent  <= 8'd0;
    end else begin
      r_drop <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= bus.in_data;
            r_mode  <= bus.mode;
            r_sel   <= bus.mode ? bus.in_dest : r_rr;
            r_timer <= '0;
            r_tries <= 2'd0;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Ready wins over a coincident timeout.
          if (w_sel_ready) begin
            r_sent  <= r_sent + 8'd1;
            r_rr    <= r_sel + 2'd1;
            r_state <= S_IDLE;
          end else if (!w_timeout) begin
            r_timer <= r_timer + 1'b1;
          end else if (w_retry) begin
            r_sel   <= r_sel + 2'd1;
            r_tries <= r_tries + 2'd1;
            r_timer <= '0;
          end else begin
            r_drop  <= 1'b1;
            r_rr    <= r_sel + 2'd1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.a        = r_a;
  assign bus.sel      = r_sel;
  assign bus.ch_valid = (r_state == S_HOLD) ? (4'b0001 << r_sel) : 4'b0000;
  assign bus.drop     = r_drop;
  assign bus.sent_cnt = r_sent;

endmodule

// File: tb/tb_demux_dispatcher.sv
// Scoreboard bench for demux_dispatcher: stimulus pushes expected retirements,
// a negedge monitor pops and compares each delivery or drop the DUT presents.
module tb_demux_dispatcher;

  logic clk;
  logic rst;

  demux_dispatcher_if #(.DW(2)) bus ();

  demux_dispatcher #(.DW(2), .TIMEOUT(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    bit is_drop;
    int data;
    int sel;
    int cycles;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input bit is_drop, input int data, input int sel, input int cycles);
    exp_t e;
    e.is_drop = is_drop;
    e.data    = data;
    e.sel     = sel;
    e.cycles  = cycles;
    q.push_back(e);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk({nm, "_idle_timeout"}, 0, 1);
  endtask

  // Returns at posedge+1 of the accepting edge: the word is in its first HOLD cycle.
  task automatic send(input int data, input int dest, input bit m);
    wait_idle("send");
    bus.in_data  = 2'(data);
    bus.in_dest  = 2'(dest);
    bus.mode     = m;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Monitor: counts CH_VALID cycles of the current word and checks each retirement.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0;
      end else begin
        if (bus.ch_valid != 4'b0000) cyc++;
        if (bus.ch_valid != 4'b0000 && bus.ch_ready[bus.sel]) begin
          if (q.size() == 0) begin
            chk("unexpected_delivery", 1, 0);
          end else begin
            e = q.pop_front();
            chk("retire_kind_deliver", 0, int'(e.is_drop));
            chk("deliver_data", int'(bus.a), e.data);
            chk("deliver_sel", int'(bus.sel), e.sel);
            chk("deliver_ch_valid", int'(bus.ch_valid), 1 << e.sel);
            chk("deliver_cycles", cyc, e.cycles);
          end
          cyc = 0;
        end
        if (bus.drop) begin
          if (q.size() == 0) begin
            chk("unexpected_drop", 1, 0);
          end else begin
            e = q.pop_front();
            chk("retire_kind_drop", 1, int'(e.is_drop));
            chk("drop_data", int'(bus.a), e.data);
            chk("drop_sel", int'(bus.sel), e.sel);
            chk("drop_cycles", cyc, e.cycles);
            chk("drop_ch_valid", int'(bus.ch_valid), 0);
          end
          cyc = 0;
        end
      end
    end
  end

  initial begin
    int n;
    rst          = 1'b1;
    bus.in_data  = '0;
    bus.in_dest  = '0;
    bus.mode     = 1'b0;
    bus.in_valid = 1'b0;
    bus.ch_ready = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_ch_valid", int'(bus.ch_valid), 0);
    chk("rst_sel", int'(bus.sel), 0);
    chk("rst_a", int'(bus.a), 0);
    chk("rst_drop", int'(bus.drop), 0);
    chk("rst_sent", int'(bus.sent_cnt), 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", int'(bus.in_ready), 1);

    // 1: round-robin over all channels, every sink ready
    bus.ch_ready = 4'b1111;
    push(0, 1, 0, 1); send(1, 0, 0);
    push(0, 2, 1, 1); send(2, 0, 0);
    push(0, 3, 2, 1); send(3, 0, 0);
    push(0, 0, 3, 1); send(0, 0, 0);
    wait_idle("t1");
    chk("t1_sent", int'(bus.sent_cnt), 4);

    // 2: directed to channel 2
    bus.ch_ready = 4'b0100;
    push(0, 3, 2, 1);
    send(3, 2, 1);
    chk("t2_a", int'(bus.a), 3);
    chk("t2_sel", int'(bus.sel), 2);
    chk("t2_ch_valid", int'(bus.ch_valid), 4'b0100);
    wait_idle("t2");
    chk("t2_sent", int'(bus.sent_cnt), 5);

    // 3: directed to an idle channel -> drop after 8 cycles
    bus.ch_ready = 4'b0000;
    push(1, 2, 1, 8);
    send(2, 1, 1);
    repeat (7) @(posedge clk);
    #1;
    chk("t3_ch_valid_c8", int'(bus.ch_valid), 4'b0010);
    chk("t3_drop_early", int'(bus.drop), 0);
    @(posedge clk);
    #1;
    chk("t3_drop_pulse", int'(bus.drop), 1);
    chk("t3_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    chk("t3_drop_clear", int'(bus.drop), 0);
    chk("t3_sent", int'(bus.sent_cnt), 5);

    // 4: round-robin retarget 0 -> 1 -> 2, delivered on 2; MODE change in HOLD ignored
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("t4_sent_reset", int'(bus.sent_cnt), 0);
    bus.ch_ready = 4'b0100;
    push(0, 1, 2, 17);
    send(1, 0, 0);
    bus.mode    = 1'b1;
    bus.in_dest = 2'd3;
    chk("t4_sel_c1", int'(bus.sel), 0);
    repeat (7) @(posedge clk);
    #1;
    chk("t4_sel_c8", int'(bus.sel), 0);
    @(posedge clk);
    #1;
    chk("t4_sel_c9", int'(bus.sel), 1);
    repeat (7) @(posedge clk);
    #1;
    chk("t4_sel_c16", int'(bus.sel), 1);
    @(posedge clk);
    #1;
    chk("t4_sel_c17", int'(bus.sel), 2);
    chk("t4_ch_valid_c17", int'(bus.ch_valid), 4'b0100);
    wait_idle("t4a");
    bus.ch_ready = 4'b1000;
    push(0, 2, 3, 1);
    send(2, 0, 0);
    wait_idle("t4b");
    chk("t4_sent", int'(bus.sent_cnt), 2);

    // 5: round-robin with no sink ready -> 32 cycles then drop
    bus.ch_ready = 4'b0000;
    push(1, 3, 3, 32);
    send(3, 0, 0);
    wait_idle("t5");
    @(posedge clk);
    #1;
    chk("t5_sent", int'(bus.sent_cnt), 2);

    // 6: reset in HOLD clears outputs without a clock edge
    push(0, 0, 0, 0);
    q.pop_back();
    send(2, 2, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_ch_valid", int'(bus.ch_valid), 0);
    chk("t6_sel", int'(bus.sel), 0);
    chk("t6_a", int'(bus.a), 0);
    chk("t6_in_ready", int'(bus.in_ready), 0);
    chk("t6_sent", int'(bus.sent_cnt), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_no_drop", int'(bus.drop), 0);

    // 7: ready arriving on the timeout cycle delivers, rr then advances to 1
    bus.ch_ready = 4'b0000;
    push(0, 1, 0, 8);
    send(1, 0, 0);
    repeat (7) @(posedge clk);
    #1;
    bus.ch_ready = 4'b0001;
    wait_idle("t7a");
    bus.ch_ready = 4'b1111;
    push(0, 3, 1, 1);
    send(3, 0, 0);
    wait_idle("t7b");
    chk("t7_sent", int'(bus.sent_cnt), 2);

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
